// File: rtl/nibble_pkg.sv
// -----------------------------------------------------------------------------
// nibble_pkg
// Shared definitions for the nibble packer.
//   NIB_W_DEF    : default nibble width in bits
//   pack_state_t : packer FSM states (FILL gathers nibbles, HOLD presents a word)
//   cnt_w(n)     : width of a counter that must represent 0..n inclusive
// -----------------------------------------------------------------------------
package nibble_pkg;

    localparam int NIB_W_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : nibble_pkg

// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Gathers NIB_W-bit nibbles from a valid/ready input stream into one packed
// word of NIBS nibbles and presents it on a valid/ready output stream.
// An accepted nibble with in_last set closes the word early; unfilled slots
// read as zero.
//
// Handshake rule (both ports): a transfer happens only at a posedge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer. in_ready and out_valid/out_* are decoded purely
// from registered state, so there is no combinational valid->ready path.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data/in_last valid this cycle
//   in_ready   out  block accepts a nibble this cycle (FILL state)
//   in_data    in   nibble payload
//   in_last    in   accepted nibble terminates the current word
//   out_valid  out  out_data/out_cnt/out_last valid (HOLD state)
//   out_ready  in   downstream accepts the word
//   out_data   out  packed word, first accepted nibble in bits [NIB_W-1:0]
//   out_cnt    out  number of valid nibbles in out_data (1..NIBS)
//   out_last   out  word was closed by in_last rather than by filling
//   dbg_state  -    (internal) state_q is an enum of pack_state_t, visible
//                   hierarchically for checkers
// -----------------------------------------------------------------------------
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int NIB_W = NIB_W_DEF,
    parameter int NIBS  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIB_W-1:0]            in_data,
    input  logic                        in_last,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIB_W*NIBS-1:0]       out_data,
    output logic [cnt_w(NIBS)-1:0]      out_cnt,
    output logic                        out_last
);

    localparam int CW = cnt_w(NIBS);
    localparam int WW = NIB_W * NIBS;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    pack_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;    // next free slot while in FILL
    logic [WW-1:0]   word_q,  word_d;   // word being assembled / held
    logic [CW-1:0]   ocnt_q,  ocnt_d;   // captured nibble count of closed word
    logic            olast_q, olast_d;  // word was closed by in_last

    logic            in_xfer;
    logic            out_xfer;
    logic            closing;

    // ---------------------------------------------------------------------
    // Registered-state decodes for the handshake outputs
    // ---------------------------------------------------------------------
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);

    // Outputs read as zero outside HOLD so a partial word is never visible.
    assign out_data  = (state_q == HOLD) ? word_q  : '0;
    assign out_cnt   = (state_q == HOLD) ? ocnt_q  : '0;
    assign out_last  = (state_q == HOLD) ? olast_q : 1'b0;

    assign in_xfer   = in_valid  && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // The word closes on the slot that fills it or on an explicit last.
    assign closing   = in_xfer && ((cnt_q == CW'(NIBS - 1)) || in_last);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        ocnt_d  = ocnt_q;
        olast_d = olast_q;

        unique case (state_q)
            FILL: begin
                if (in_xfer) begin
                    // Slot select by compare keeps the write index bounded
                    // to legal slots even if cnt_q were corrupted.
                    for (int i = 0; i < NIBS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            word_d[i*NIB_W +: NIB_W] = in_data;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                if (closing) begin
                    state_d = HOLD;
                    ocnt_d  = cnt_q + CW'(1);
                    olast_d = in_last;
                end
            end

            HOLD: begin
                if (out_xfer) begin
                    // Start the next word from a clean slate so short words
                    // never inherit stale nibbles.
                    state_d = FILL;
                    cnt_d   = '0;
                    word_d  = '0;
                    ocnt_d  = '0;
                    olast_d = 1'b0;
                end
            end

            default: begin
                state_d = FILL;
                cnt_d   = '0;
                word_d  = '0;
                ocnt_d  = '0;
                olast_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers (reset wins over any transfer in the same cycle)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            ocnt_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ocnt_q  <= ocnt_d;
            olast_q <= olast_d;
        end
    end

endmodule : nibble_packer

// File: tb/tb_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_nibble_packer
// Self-checking bench for nibble_packer (NIB_W=4, NIBS=4).
// Directed table vectors, hand-written corner sequences and a randomized run,
// all checked against a word-level reference model built from queues.
// -----------------------------------------------------------------------------
module tb_nibble_packer;

    localparam int NIB_W = 4;
    localparam int NIBS  = 4;
    localparam int WW    = NIB_W * NIBS;
    localparam int CW    = $clog2(NIBS + 1);

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NIB_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WW-1:0]    out_data;
    logic [CW-1:0]    out_cnt;
    logic             out_last;

    always #5 clk = ~clk;

    nibble_packer #(.NIB_W(NIB_W), .NIBS(NIBS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_last  (out_last)
    );

    // ---------------------------------------------------------------------
    // Scoreboard / reference model
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [WW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } word_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [NIB_W-1:0] cur_q[$];   // nibbles of the word being gathered
    word_t            exp_q[$];   // closed words awaiting output transfer

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur_q.delete();
        exp_q.delete();
    endtask

    // Compare the DUT's registered outputs with what the model predicts now.
    task automatic model_check();
        if (exp_q.size() != 0) begin
            chk("in_ready_hold", 32'(in_ready), 32'd0);
            chk("out_valid_hold", 32'(out_valid), 32'd1);
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_cnt", 32'(out_cnt), 32'(exp_q[0].cnt));
            chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        end else begin
            chk("in_ready_fill", 32'(in_ready), 32'd1);
            chk("out_valid_fill", 32'(out_valid), 32'd0);
        end
    endtask

    // One clock: drive inputs, check current outputs, advance model, clock.
    task automatic cycle(input logic v, input logic [NIB_W-1:0] d, input logic l,
                         input logic ordy);
        word_t w;
        in_valid  = v;
        in_data   = v ? d : 'x;
        in_last   = v ? l : 'x;
        out_ready = ordy;
        model_check();
        if (exp_q.size() != 0) begin
            if (ordy) void'(exp_q.pop_front());
        end else if (v) begin
            cur_q.push_back(d);
            if (cur_q.size() == NIBS || l) begin
                w.data = '0;
                foreach (cur_q[i]) w.data = w.data | (WW'(cur_q[i]) << (NIB_W * i));
                w.cnt  = CW'(cur_q.size());
                w.last = l;
                exp_q.push_back(w);
                cur_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = NIB_W'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_cnt", 32'(out_cnt), 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        model_clear();
    endtask

    // ---------------------------------------------------------------------
    // Directed table: each row is applied for one clock, then the outputs
    // just after that edge are compared with the row's expectations.
    // ---------------------------------------------------------------------
    typedef struct {
        logic             v;
        logic [NIB_W-1:0] d;
        logic             l;
        logic             ordy;
        logic             e_rdy;
        logic             e_vld;
        logic [WW-1:0]    e_data;
        logic [CW-1:0]    e_cnt;
        logic             e_last;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // full word B,3,7,1 back to back
        vecs[0]  = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h173B, 3'd4, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        // early flush A,5(last)
        vecs[5]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 16'h005A, 3'd2, 1'b1};
        vecs[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        // single-nibble word, zeroed upper slots
        vecs[8]  = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0006, 3'd1, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        // last on the NIBS-th nibble
        vecs[10] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[11] = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[12] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[13] = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBA98, 3'd4, 1'b1};
        vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held 2 cycles with in_valid high: nothing captured
        do_reset(2);

        // Table vectors
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_out_cnt", i), 32'(out_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(vecs[i].e_last));
        end

        // Backpressure: word 4321 held 6 cycles while nibble 9 waits
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h4321);
            cycle(1'b1, 4'h9, 1'b0, 1'b0);
        end
        chk("bp_stable_data", 32'(out_data), 32'h4321);
        cycle(1'b1, 4'h9, 1'b0, 1'b1);      // output transfer only
        chk("bp_ready_after", 32'(in_ready), 32'd1);
        cycle(1'b1, 4'h9, 1'b0, 1'b1);      // 9 lands in slot 0
        cycle(1'b1, 4'h8, 1'b0, 1'b1);
        cycle(1'b1, 4'h7, 1'b0, 1'b1);
        cycle(1'b1, 4'h6, 1'b0, 1'b1);
        chk("bp_next_word", 32'(out_data), 32'h6789);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Mid-word reset discards partial nibbles
        cycle(1'b1, 4'h5, 1'b0, 1'b1);
        cycle(1'b1, 4'h6, 1'b0, 1'b1);
        do_reset(1);
        cycle(1'b1, 4'hF, 1'b0, 1'b1);
        cycle(1'b1, 4'hE, 1'b0, 1'b1);
        cycle(1'b1, 4'hD, 1'b0, 1'b1);
        cycle(1'b1, 4'hC, 1'b0, 1'b1);
        chk("mid_rst_data", 32'(out_data), 32'hCDEF);
        chk("mid_rst_cnt", 32'(out_cnt), 32'd4);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Input gaps with X payload while in_valid is low
        cycle(1'b1, 4'h2, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 4'h4, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 4'h6, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 4'h8, 1'b0, 1'b1);
        chk("gap_data", 32'(out_data), 32'h8642);
        chk("gap_no_x", 32'($isunknown(out_data)), 32'd0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), NIB_W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) != 0));
            if ($isunknown(out_data)) chk("rand_no_x", 32'd1, 32'd0);
        end
        // Drain any held word
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
        model_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nibble_packer
